// File: rtl/msdap_ctrl.sv
// Sequencing FSM for the MSDAP front end: configuration load, per-sample
// compute launch, silence-driven sleep/wake and memory clear control.
module msdap_ctrl #(
  parameter int CLR_CYCLES   = 512,
  parameter int SLEEP_THRESH = 800,
  parameter int ZCNT_W       = 11
) (
  input  logic        dClk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        frame,
  input  logic        softReset_n,
  input  logic        s2pDone,
  input  logic [15:0] dataInL,
  input  logic [15:0] dataInR,
  output logic [3:0]  FSMState,
  output logic        inReady,
  output logic        resetDataDone_n,
  output logic        wakeupSignal,
  output logic        computeStart,
  output logic        memClear,
  output logic        sleepFlag
);

  localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CLR_W-1:0]  CLR_LAST = CLR_W'(CLR_CYCLES - 1);
  localparam logic [CLR_W-1:0]  CLR_ONE  = CLR_W'(1);
  localparam logic [ZCNT_W-1:0] Z_THR    = ZCNT_W'(SLEEP_THRESH);
  localparam logic [ZCNT_W-1:0] Z_ONE    = ZCNT_W'(1);

  typedef enum logic [3:0] {
    INIT       = 4'b0000,
    WAIT_RJ    = 4'b0001,
    READ_RJ    = 4'b0010,
    WAIT_COEFF = 4'b0011,
    READ_COEFF = 4'b0100,
    WAIT_INPUT = 4'b0101,
    WORKING    = 4'b0110,
    CLEARING   = 4'b0111,
    SLEEPING   = 4'b1000
  } state_t;

  state_t             state, nxt;
  logic [CLR_W-1:0]   clrCnt, clrNxt;
  logic [ZCNT_W-1:0]  zeroCnt, zeroNxt, zeroInc;
  logic               doneD, doneRise, zeroPair, softHit;
  logic               computeNxt, wakeNxt;

  assign doneRise = s2pDone & ~doneD;
  assign zeroPair = (dataInL == 16'd0) && (dataInR == 16'd0);
  assign zeroInc  = (&zeroCnt) ? zeroCnt : zeroCnt + Z_ONE;
  assign softHit  = !softReset_n &&
                    ((state == WAIT_INPUT) || (state == WORKING) || (state == SLEEPING));
  assign FSMState = state;

  always_comb begin
    nxt        = state;
    clrNxt     = clrCnt;
    zeroNxt    = zeroCnt;
    computeNxt = 1'b0;
    wakeNxt    = 1'b0;
    case (state)
      INIT: begin
        if (clrCnt == CLR_LAST) begin
          clrNxt = '0;
          nxt    = WAIT_RJ;
        end else begin
          clrNxt = clrCnt + CLR_ONE;
        end
      end
      WAIT_RJ:    if (start)    nxt = READ_RJ;
      READ_RJ:    if (doneRise) nxt = WAIT_COEFF;
      WAIT_COEFF: if (frame)    nxt = READ_COEFF;
      READ_COEFF: if (doneRise) nxt = WAIT_INPUT;
      WAIT_INPUT: if (frame)    nxt = WORKING;
      WORKING: begin
        if (doneRise) begin
          computeNxt = 1'b1;
          if (zeroPair) begin
            zeroNxt = zeroInc;
            if (zeroInc == Z_THR) nxt = SLEEPING;
          end else begin
            zeroNxt = '0;
          end
        end
      end
      SLEEPING: begin
        if (doneRise && !zeroPair) begin
          computeNxt = 1'b1;
          wakeNxt    = 1'b1;
          zeroNxt    = '0;
          nxt        = WORKING;
        end
      end
      CLEARING: begin
        // A soft reset still held at the end of a clear simply restarts it.
        if (clrCnt == CLR_LAST) begin
          clrNxt = '0;
          nxt    = softReset_n ? WAIT_INPUT : CLEARING;
        end else begin
          clrNxt = clrCnt + CLR_ONE;
        end
      end
      default: begin
        nxt     = INIT;
        clrNxt  = '0;
        zeroNxt = '0;
      end
    endcase
    // Soft reset wins over any sample arriving in the same cycle.
    if (softHit) begin
      nxt        = CLEARING;
      clrNxt     = '0;
      zeroNxt    = '0;
      computeNxt = 1'b0;
      wakeNxt    = 1'b0;
    end
  end

  always_ff @(posedge dClk) begin
    if (!reset_n) begin
      state           <= INIT;
      clrCnt          <= '0;
      zeroCnt         <= '0;
      doneD           <= 1'b0;
      inReady         <= 1'b0;
      resetDataDone_n <= 1'b1;
      wakeupSignal    <= 1'b0;
      computeStart    <= 1'b0;
      memClear        <= 1'b1;
      sleepFlag       <= 1'b0;
    end else begin
      state           <= nxt;
      clrCnt          <= clrNxt;
      zeroCnt         <= zeroNxt;
      doneD           <= s2pDone;
      inReady         <= (nxt != INIT) && (nxt != CLEARING);
      memClear        <= (nxt == INIT) || (nxt == CLEARING);
      sleepFlag       <= (nxt == SLEEPING);
      resetDataDone_n <= ~doneRise;
      computeStart    <= computeNxt;
      wakeupSignal    <= wakeNxt;
    end
  end

endmodule

// File: tb/tb_msdap_ctrl.sv
// Bench for msdap_ctrl: table of sample vectors plus hand-built sequences;
// every receiver acknowledge pops an expected record from a scoreboard queue.
module tb_msdap_ctrl;

  logic        dClk = 1'b0;
  logic        reset_n, start, frame, softReset_n, s2pDone;
  logic [15:0] dataInL, dataInR;
  logic [3:0]  FSMState;
  logic        inReady, resetDataDone_n, wakeupSignal, computeStart, memClear, sleepFlag;

  msdap_ctrl dut (
    .dClk(dClk), .reset_n(reset_n), .start(start), .frame(frame),
    .softReset_n(softReset_n), .s2pDone(s2pDone),
    .dataInL(dataInL), .dataInR(dataInR),
    .FSMState(FSMState), .inReady(inReady), .resetDataDone_n(resetDataDone_n),
    .wakeupSignal(wakeupSignal), .computeStart(computeStart),
    .memClear(memClear), .sleepFlag(sleepFlag)
  );

  always #5 dClk = ~dClk;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic        cs;
    logic        wk;
    logic [3:0]  st;
  } vec_t;

  vec_t sb[$];
  vec_t popped;
  vec_t tbl[5];
  int   passed = 0;
  int   total  = 0;
  int   csCount = 0;
  int   expCs   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
  endtask

  task automatic tick();
    @(posedge dClk);
    #1;
  endtask

  // Every acknowledge pulse corresponds to one done edge the bench issued.
  always @(negedge dClk) begin
    if (computeStart === 1'b1) csCount++;
    if (resetDataDone_n === 1'b0) begin
      if (sb.size() == 0) begin
        chk("ack_unexpected", 32'd1, 32'd0);
      end else begin
        popped = sb.pop_front();
        chk("sb_computeStart", computeStart, popped.cs);
        chk("sb_wakeup", wakeupSignal, popped.wk);
        chk("sb_state", FSMState, popped.st);
        chk("sb_sleepFlag", sleepFlag, popped.st == 4'b1000);
      end
    end
  end

  task automatic push(input logic [15:0] l, r, input logic cs, wk, input logic [3:0] st);
    vec_t v;
    v = '{l, r, cs, wk, st};
    sb.push_back(v);
    if (cs) expCs++;
  endtask

  task automatic send(input logic [15:0] l, r, input logic cs, wk, input logic [3:0] st);
    dataInL = l;
    dataInR = r;
    s2pDone = 1'b1;
    push(l, r, cs, wk, st);
    tick();
    s2pDone = 1'b0;
    tick();
    chk("computeStart_width", computeStart, 1'b0);
    chk("wakeup_width", wakeupSignal, 1'b0);
  endtask

  task automatic count_clear(input string nm);
    int n;
    n = 1;
    do begin
      tick();
      if (memClear) n++;
    end while (memClear && n < 600);
    chk(nm, n, 512);
  endtask

  initial begin
    tbl[0] = '{16'h1234, 16'h0000, 1'b1, 1'b0, 4'h6};
    tbl[1] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 4'h6};
    tbl[2] = '{16'h0000, 16'h8000, 1'b1, 1'b0, 4'h6};
    tbl[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 4'h6};
    tbl[4] = '{16'h0000, 16'h0001, 1'b1, 1'b0, 4'h6};

    reset_n = 1'b0; start = 1'b0; frame = 1'b0; softReset_n = 1'b1;
    s2pDone = 1'b0; dataInL = '0; dataInR = '0;
    tick(); tick();
    chk("rst_state", FSMState, 4'b0000);
    chk("rst_inReady", inReady, 1'b0);
    chk("rst_ack", resetDataDone_n, 1'b1);
    chk("rst_wakeup", wakeupSignal, 1'b0);
    chk("rst_compute", computeStart, 1'b0);
    chk("rst_memClear", memClear, 1'b1);
    chk("rst_sleep", sleepFlag, 1'b0);

    reset_n = 1'b1;
    count_clear("init_clear_len");
    chk("wait_rj_state", FSMState, 4'b0001);
    chk("wait_rj_inReady", inReady, 1'b1);

    start = 1'b1; tick(); start = 1'b0;
    chk("read_rj_state", FSMState, 4'b0010);
    repeat (16) tick();
    // Done held three cycles must be acknowledged once.
    s2pDone = 1'b1;
    push(16'h0, 16'h0, 1'b0, 1'b0, 4'b0011);
    repeat (3) tick();
    s2pDone = 1'b0;
    tick();
    chk("wait_coeff_state", FSMState, 4'b0011);

    frame = 1'b1; tick(); frame = 1'b0;
    chk("read_coeff_state", FSMState, 4'b0100);
    repeat (8) tick();
    send(16'h0, 16'h0, 1'b0, 1'b0, 4'b0101);
    chk("wait_input_state", FSMState, 4'b0101);
    frame = 1'b1; tick(); frame = 1'b0;
    chk("working_state", FSMState, 4'b0110);

    for (int i = 0; i < 5; i++) send(tbl[i].l, tbl[i].r, tbl[i].cs, tbl[i].wk, tbl[i].st);

    for (int i = 0; i < 800; i++) send(16'h0, 16'h0, 1'b1, 1'b0, (i == 799) ? 4'b1000 : 4'b0110);
    chk("sleep_flag", sleepFlag, 1'b1);
    chk("sleep_state", FSMState, 4'b1000);
    chk("sleep_inReady", inReady, 1'b1);
    send(16'h0, 16'h0, 1'b0, 1'b0, 4'b1000);
    send(16'h0001, 16'h0, 1'b1, 1'b1, 4'b0110);
    chk("woke_sleepFlag", sleepFlag, 1'b0);

    for (int i = 0; i < 799; i++) send(16'h0, 16'h0, 1'b1, 1'b0, 4'b0110);
    send(16'h0, 16'h0040, 1'b1, 1'b0, 4'b0110);
    for (int i = 0; i < 799; i++) send(16'h0, 16'h0, 1'b1, 1'b0, 4'b0110);
    chk("no_sleep_state", FSMState, 4'b0110);
    chk("no_sleep_flag", sleepFlag, 1'b0);

    // Soft reset coincident with a sample: acknowledged but no compute.
    dataInL = 16'h0005; dataInR = 16'h0;
    softReset_n = 1'b0;
    s2pDone = 1'b1;
    push(16'h0005, 16'h0, 1'b0, 1'b0, 4'b0111);
    tick();
    s2pDone = 1'b0;
    softReset_n = 1'b1;
    chk("clr_state", FSMState, 4'b0111);
    chk("clr_inReady", inReady, 1'b0);
    count_clear("soft_clear_len");
    chk("after_clr_state", FSMState, 4'b0101);
    chk("after_clr_inReady", inReady, 1'b1);

    softReset_n = 1'b0; tick(); softReset_n = 1'b1;
    chk("clr2_state", FSMState, 4'b0111);
    repeat (100) tick();
    chk("clr2_memClear", memClear, 1'b1);
    reset_n = 1'b0; tick();
    chk("midclr_rst_state", FSMState, 4'b0000);
    chk("midclr_rst_memClear", memClear, 1'b1);
    chk("midclr_rst_inReady", inReady, 1'b0);
    reset_n = 1'b1;
    tick(); tick();

    chk("sb_empty", sb.size(), 0);
    chk("compute_total", csCount, expCs);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/msdap_ctrl.md
Name: msdap_ctrl

Overview:
Top-level sequencing FSM for the MSDAP front end. Drives the 4-bit FSMState and handshake signals that the serial-to-parallel receiver uses to route Rj, coefficient and data words. It acknowledges each receiver done, launches per-sample compute, detects input silence to enter and leave sleep, and runs memory clears at init and on soft reset.

Parameters:
CLR_CYCLES, 512, cycles memClear is held high in INIT and CLEARING (covers the deepest memory)
SLEEP_THRESH, 800, consecutive all-zero sample pairs that trigger SLEEPING
ZCNT_W, 11, zero-run counter width; must satisfy 2^ZCNT_W > SLEEP_THRESH

Ports:
dClk  input  1  system clock; all state changes on posedge
reset_n  input  1  synchronous active-low reset
start  input  1  begins configuration load; sampled only in WAIT_RJ
frame  input  1  word-start strobe from the main controller
softReset_n  input  1  active-low data-clear request from the main controller
s2pDone  input  1  done flag from the receiver (level; cleared through resetDataDone_n)
dataInL  input  16  last assembled left word (receiver toMemL)
dataInR  input  16  last assembled right word (receiver toMemR)
FSMState  output  4  current state code
inReady  output  1  receiver enable
resetDataDone_n  output  1  one-cycle active-low pulse that clears s2pDone
wakeupSignal  output  1  one-cycle pulse on leaving SLEEPING
computeStart  output  1  one-cycle pulse per accepted sample in WORKING
memClear  output  1  memory clear enable
sleepFlag  output  1  high while in SLEEPING

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Clock dClk, reset reset_n.
- Reset (reset_n=0 at posedge, overrides everything): state INIT; clrCnt=0; zeroCnt=0; doneD=0. Outputs: FSMState=0000, inReady=0, resetDataDone_n=1, wakeupSignal=0, computeStart=0, memClear=1, sleepFlag=0.
- State codes: INIT 0000, WAIT_RJ 0001, READ_RJ 0010, WAIT_COEFF 0011, READ_COEFF 0100, WAIT_INPUT 0101, WORKING 0110, CLEARING 0111, SLEEPING 1000. Codes 0010, 0100 and 0110 are fixed by the receiver. Unused codes go to INIT on the next edge.
- doneRise = s2pDone & ~doneD, where doneD is s2pDone registered. Every doneRise produces resetDataDone_n=0 for exactly the next cycle. Only a rising edge is acted on, so one s2pDone assertion is never counted twice.
- INIT: memClear=1, clrCnt increments. At clrCnt==CLR_CYCLES-1, clrCnt goes to 0 and the state goes to WAIT_RJ.
- WAIT_RJ: inReady=1. start=1 goes to READ_RJ.
- READ_RJ: on doneRise (all 16 Rj loaded), go to WAIT_COEFF.
- WAIT_COEFF: on frame=1, go to READ_COEFF.
- READ_COEFF: on doneRise (all 512 coefficients loaded), go to WAIT_INPUT.
- WAIT_INPUT: on frame=1, go to WORKING.
- Registered outputs: inReady=1 in every state except INIT and CLEARING. memClear=1 only in INIT and CLEARING. sleepFlag=1 only in SLEEPING.
- WORKING, on doneRise:
  - computeStart=1 next cycle.
  - If dataInL==0 and dataInR==0, zeroCnt increments (saturating); otherwise zeroCnt=0.
  - When the increment makes zeroCnt==SLEEP_THRESH, go to SLEEPING. That sample still gets its computeStart.
- SLEEPING, on doneRise:
  - Zero pair: stay, no computeStart.
  - Nonzero pair: next cycle wakeupSignal=1 and computeStart=1, zeroCnt=0, state WORKING.
- Soft reset: softReset_n=0 in WAIT_INPUT, WORKING or SLEEPING goes to CLEARING, clears zeroCnt and clrCnt, and ignores a same-cycle doneRise (no computeStart, no wake). softReset_n is ignored in all other states.
- CLEARING: memClear=1 for CLR_CYCLES cycles, then WAIT_INPUT. Rj and coefficient memories are untouched. If softReset_n is still low at that exit, go to CLEARING again.
- reset_n=0 in mid-operation in any state, including mid-clear: full reset as above on that edge.
- All outputs are registered. Latency from doneRise to the pulses is 1 cycle.

Test Plan:
- Reset, then hold reset_n=1 for 512 cycles: memClear high for exactly 512 cycles, then FSMState=0001 and inReady=1.
- start, then 16 Rj words and receiver done: FSMState goes 0001→0010→0011, with a resetDataDone_n low pulse of 1 cycle; holding s2pDone high 3 cycles gives only one pulse.
- Coeff load, then frame: FSMState 0100→0101→0110. The first nonzero sample gives computeStart=1 one cycle after doneRise.
- 800 zero pairs in WORKING: 800 computeStart pulses, sleepFlag=1 and FSMState=1000 after the 800th. Then a pair L=0x0001, R=0: wakeupSignal and computeStart high together for 1 cycle, FSMState=0110.
- 799 zeros, one nonzero, then 799 zeros: never enters SLEEPING.
- softReset_n=0 in WORKING, coincident with doneRise: no computeStart, state 0111, memClear 512 cycles, then 0101. A following reset_n=0 mid-CLEARING gives FSMState=0000 next edge.
